// File: rtl/dmem_pkg.sv
// Shared types for the core data-port to SRAM bridge.
//   dsize_e   : DSIZE encodings
//   state_e   : bridge FSM states
//   dreq_t    : captured core request
//   lane_mask : 8-lane byte mask for a size at a byte offset (lanes 4..7 spill to word+1)
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dsize_e;

  typedef enum logic [2:0] {
    StIdle,
    StBeat1,
    StBeat2,
    StWait,
    StDone
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        rw;
    dsize_e      size;
    logic        sign;
    logic [31:0] wdata;
  } dreq_t;

  function automatic logic [7:0] lane_mask(input dsize_e size, input logic [1:0] off);
    logic [7:0] base;
    unique case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational lane steering for the data-memory bridge.
//   offset    : byte offset within the word (DADDR[1:0])
//   size      : access size
//   sign      : sign-extend (1) / zero-extend (0) read data
//   wdata     : right-justified write data
//   rmerged   : read bytes as they sit on the SRAM lanes (both beats merged)
//   be_lo     : byte enables of the first beat (word W)
//   be_hi     : byte enables of the second beat (word W+1)
//   spill     : access crosses into word W+1
//   wdata_rot : write data rotated onto the SRAM lanes
//   rdata     : right-justified, extended read result
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic [1:0]  offset,
  input  dsize_e      size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rmerged,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic        spill,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata
);

  logic [7:0]  mask;
  logic [31:0] rrot;

  always_comb begin
    mask  = lane_mask(size, offset);
    be_lo = mask[3:0];
    be_hi = mask[7:4];
    spill = |mask[7:4];
  end

  // Rotate left for writes, right for reads, by 8*offset.
  always_comb begin
    wdata_rot = wdata;
    rrot      = rmerged;
    unique case (offset)
      2'd0: begin
        wdata_rot = wdata;
        rrot      = rmerged;
      end
      2'd1: begin
        wdata_rot = {wdata[23:0], wdata[31:24]};
        rrot      = {rmerged[7:0], rmerged[31:8]};
      end
      2'd2: begin
        wdata_rot = {wdata[15:0], wdata[31:16]};
        rrot      = {rmerged[15:0], rmerged[31:16]};
      end
      2'd3: begin
        wdata_rot = {wdata[7:0], wdata[31:8]};
        rrot      = {rmerged[23:0], rmerged[31:24]};
      end
    endcase
  end

  always_comb begin
    rdata = rrot;
    unique case (size)
      SZ_BYTE: rdata = {{24{sign & rrot[7]}}, rrot[7:0]};
      SZ_HALF: rdata = {{16{sign & rrot[15]}}, rrot[15:0]};
      default: rdata = rrot;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// CortexM0 data port to synchronous SRAM bridge.
// Adds a DRDY/DERR completion handshake, programmable SRAM read latency, lane steering,
// read extension and optional splitting of misaligned accesses into two SRAM beats.
// Ports:
//   CLK, RESET_N                       : clock, async active-low reset
//   DREQ/DADDR/DRW/DSIZE/DSIGN/DOUT    : core request, held until DRDY
//   DIN/DRDY/DERR                      : registered read data, completion pulse, error flag
//   MEM_CSN/MEM_ADDR/MEM_WE/MEM_BE/MEM_DI : registered SRAM beat signals
//   MEM_DO                             : SRAM read data, READ_LAT cycles after its beat
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned MISALIGN_EN = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              DREQ,
  input  logic [31:0]       DADDR,
  input  logic              DRW,
  input  logic [1:0]        DSIZE,
  input  logic              DSIGN,
  input  logic [31:0]       DOUT,
  output logic [31:0]       DIN,
  output logic              DRDY,
  output logic              DERR,
  output logic              MEM_CSN,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DO
);

  localparam bit SplitOk = (MISALIGN_EN != 0);

  state_e state_q, state_d;
  dreq_t  req_live, req_q, req_cur;
  logic   split_q;
  logic   start, req_err;

  logic [3:0]        be_lo, be_hi;
  logic              spill;
  logic [31:0]       wdata_rot, rdata;
  logic [MEM_AW-1:0] word_addr, word_next;

  logic              csn_d, we_d, derr_d;
  logic [MEM_AW-1:0] addr_d;
  logic [3:0]        be_d;
  logic [31:0]       di_d, din_d;
  logic              beat_id_q, beat_id_d;

  logic [READ_LAT-1:0] pipe_vld_q, pipe_id_q;
  logic                tap_vld, tap_id, tap_last;
  logic [3:0]          tap_be;
  logic [31:0]         rbuf_q, rbuf_d;

  logic unused_addr_hi;

  always_comb begin
    req_live.addr  = DADDR;
    req_live.rw    = DRW;
    req_live.size  = dsize_e'(DSIZE);
    req_live.sign  = DSIGN;
    req_live.wdata = DOUT;
  end

  // Live inputs steer the first beat; the captured request covers the rest, so a core that
  // drops DREQ early cannot corrupt beats already in flight.
  assign req_cur = (state_q == StIdle) ? req_live : req_q;

  dmem_lane_steer u_lane_steer (
    .offset    (req_cur.addr[1:0]),
    .size      (req_cur.size),
    .sign      (req_cur.sign),
    .wdata     (req_cur.wdata),
    .rmerged   (rbuf_d),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .spill     (spill),
    .wdata_rot (wdata_rot),
    .rdata     (rdata)
  );

  assign word_addr      = req_cur.addr[MEM_AW+1:2];
  assign word_next      = word_addr + MEM_AW'(1);
  assign unused_addr_hi = ^req_cur.addr[31:MEM_AW+2];

  assign start   = (state_q == StIdle) && DREQ;
  assign req_err = (req_live.size == SZ_RSVD) || (spill && !SplitOk);

  assign tap_vld  = pipe_vld_q[READ_LAT-1];
  assign tap_id   = pipe_id_q[READ_LAT-1];
  assign tap_last = tap_vld && (tap_id == split_q);

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (DREQ) state_d = req_err ? StDone : StBeat1;
      StBeat1: begin
        if (split_q)         state_d = StBeat2;
        else if (req_cur.rw) state_d = StDone;
        else                 state_d = StWait;
      end
      StBeat2: state_d = req_cur.rw ? StDone : StWait;
      StWait:  if (tap_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: next values of the registered SRAM and status pins
  always_comb begin
    csn_d     = 1'b1;
    we_d      = 1'b0;
    addr_d    = MEM_ADDR;
    be_d      = MEM_BE;
    di_d      = MEM_DI;
    beat_id_d = beat_id_q;
    derr_d    = 1'b0;
    DRDY      = (state_q == StDone);
    if (start) begin
      if (req_err) begin
        derr_d = 1'b1;
      end else begin
        csn_d     = 1'b0;
        we_d      = req_cur.rw;
        addr_d    = word_addr;
        be_d      = be_lo;
        di_d      = wdata_rot;
        beat_id_d = 1'b0;
      end
    end else if (state_q == StBeat1 && split_q) begin
      // Same rotated data; upper lanes land in the low lanes of the next word.
      csn_d     = 1'b0;
      we_d      = req_cur.rw;
      addr_d    = word_next;
      be_d      = be_hi;
      beat_id_d = 1'b1;
    end
  end

  // Merge arriving read bytes onto their SRAM lanes.
  always_comb begin
    tap_be = tap_id ? be_hi : be_lo;
    rbuf_d = rbuf_q;
    if (tap_vld) begin
      for (int i = 0; i < 4; i++) begin
        if (tap_be[i]) rbuf_d[8*i +: 8] = MEM_DO[8*i +: 8];
      end
    end
    din_d = DIN;
    if (state_q == StWait && tap_last) din_d = rdata;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MEM_CSN   <= 1'b1;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_BE    <= '0;
      MEM_DI    <= '0;
      DERR      <= 1'b0;
      DIN       <= '0;
      beat_id_q <= 1'b0;
      req_q     <= '0;
      split_q   <= 1'b0;
      rbuf_q    <= '0;
    end else begin
      MEM_CSN   <= csn_d;
      MEM_WE    <= we_d;
      MEM_ADDR  <= addr_d;
      MEM_BE    <= be_d;
      MEM_DI    <= di_d;
      DERR      <= derr_d;
      DIN       <= din_d;
      beat_id_q <= beat_id_d;
      rbuf_q    <= rbuf_d;
      if (start) begin
        req_q   <= req_live;
        split_q <= spill;
      end
    end
  end

  // Read tags: entry k describes the read beat that was on the pins k+1 cycles ago, so the
  // last stage lines up with MEM_DO for that beat.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q[0] <= ~MEM_CSN & ~MEM_WE;
      pipe_id_q[0]  <= beat_id_q;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

endmodule
